// File: rtl/des_pkg.sv
// DES constant tables, FSM state encodings and the table-driven bit permutation helper.
// Used by des_round_f and des_iter_ctrl (optional macro DES_KEY_PARITY_CHECK_EN lives in the top).
package des_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [2:0] {TBL_IP, TBL_FP, TBL_PC1, TBL_PC2, TBL_E, TBL_P} perm_sel_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int SHIFT_T  [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int RSHIFT_T [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int SBOX_T [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  // Result and source vectors are right-aligned in 64 bits; DES bit 1 is the MSB of each width.
  function automatic logic [63:0] des_permute(input perm_sel_t tbl, input logic [63:0] vec);
    logic [63:0] res;
    int n_out;
    int n_in;
    int src;
    res = '0;
    case (tbl)
      TBL_IP, TBL_FP: begin n_out = 64; n_in = 64; end
      TBL_PC1:        begin n_out = 56; n_in = 64; end
      TBL_PC2:        begin n_out = 48; n_in = 56; end
      TBL_E:          begin n_out = 48; n_in = 32; end
      default:        begin n_out = 32; n_in = 32; end
    endcase
    for (int i = 0; i < 64; i++) begin
      if (i < n_out) begin
        case (tbl)
          TBL_IP:  src = IP_T[6'(i)];
          TBL_FP:  src = FP_T[6'(i)];
          TBL_PC1: src = PC1_T[6'(i)];
          TBL_PC2: src = PC2_T[6'(i)];
          TBL_E:   src = E_T[6'(i)];
          default: src = P_T[5'(i)];
        endcase
        res[6'(n_out - 1 - i)] = vec[6'(n_in - src)];
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] six);
    return 4'(SBOX_T[3'(box)][{six[5], six[0], six[4:1]}]);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    case (n)
      1:       return {x[26:0], x[27]};
      2:       return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
    case (n)
      1:       return {x[0], x[27:1]};
      2:       return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_round_f.sv
// Combinational DES round function f(R, K): E-expansion, subkey XOR, S-boxes, P permutation.
module des_round_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);

  logic [47:0] x;
  logic [31:0] s_out;

  always_comb begin
    x     = 48'(des_permute(TBL_E, 64'(r))) ^ k;
    s_out = '0;
    for (int b = 0; b < 8; b++) begin
      s_out[31 - 4*b -: 4] = sbox_lookup(b, x[47 - 6*b -: 6]);
    end
    f = 32'(des_permute(TBL_P, 64'(s_out)));
  end

endmodule

// File: rtl/des_iter_ctrl.sv
// Iterative DES controller: one Feistel round per clock, subkeys generated on the fly both directions.
// Optional key parity flag enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_iter_ctrl
  import des_pkg::*;
#(
  parameter int ROUNDS   = 16,
  parameter bit HOLD_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [63:0] in_key,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_err,
  output logic        busy
);

  logic [1:0]  state;
  logic [4:0]  rnd;
  logic        dir;
  logic [31:0] l_q;
  logic [31:0] r_q;
  logic [27:0] c_q;
  logic [27:0] d_q;
  logic [63:0] data_q;

  logic [3:0]  rnd_idx;
  int          shift_amt;
  logic [27:0] c_rot;
  logic [27:0] d_rot;
  logic [47:0] subkey;
  logic [31:0] f_out;
  logic [31:0] r_next;
  logic [63:0] ip_data;
  logic [55:0] pc1_key;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_data  = (HOLD_OUT || state == ST_DONE) ? data_q : '0;

  // Decrypt walks the schedule backwards: round 1 uses the unrotated C,D, which equals K16.
  always_comb begin
    rnd_idx   = 4'(rnd - 5'd1);
    shift_amt = dir ? RSHIFT_T[rnd_idx] : SHIFT_T[rnd_idx];
    c_rot     = dir ? rotr28(c_q, shift_amt) : rotl28(c_q, shift_amt);
    d_rot     = dir ? rotr28(d_q, shift_amt) : rotl28(d_q, shift_amt);
    subkey    = 48'(des_permute(TBL_PC2, 64'({c_rot, d_rot})));
    r_next    = l_q ^ f_out;
    ip_data   = des_permute(TBL_IP, in_data);
    pc1_key   = 56'(des_permute(TBL_PC1, in_key));
  end

  des_round_f u_round_f (
    .r (r_q),
    .k (subkey),
    .f (f_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rnd    <= '0;
      dir    <= 1'b0;
      l_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            l_q   <= ip_data[63:32];
            r_q   <= ip_data[31:0];
            c_q   <= pc1_key[55:28];
            d_q   <= pc1_key[27:0];
            dir   <= in_decrypt;
            rnd   <= 5'd1;
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          l_q <= r_q;
          r_q <= r_next;
          c_q <= c_rot;
          d_q <= d_rot;
          // Final round: the halves are swapped before the final permutation.
          if (rnd == 5'(ROUNDS)) begin
            data_q <= des_permute(TBL_FP, {r_next, r_q});
            rnd    <= '0;
            state  <= ST_DONE;
          end else begin
            rnd <= rnd + 5'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic err_q;
  logic key_err;

  // Every key byte must carry odd parity; the flag rides along with the result.
  always_comb begin
    key_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!(^in_key[8*i +: 8])) key_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == ST_IDLE && in_valid) begin
      err_q <= key_err;
    end else if (state == ST_DONE && out_ready) begin
      err_q <= 1'b0;
    end
  end

  assign out_err = err_q && (state == ST_DONE);
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Self-checking bench for des_iter_ctrl using known DES vectors and an expected-result queue.
module tb_des_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_decrypt;
  logic [63:0] in_key;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_err;
  logic        busy;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] ZC = 64'h8CA64DE9C1B123A7;
`ifdef DES_KEY_PARITY_CHECK_EN
  localparam logic ZERO_KEY_ERR = 1'b1;
`else
  localparam logic ZERO_KEY_ERR = 1'b0;
`endif

  des_iter_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_decrypt (in_decrypt),
    .in_key     (in_key),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [63:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  // Presents one request, waits for acceptance, then scrambles the inputs.
  task automatic issue(input logic [63:0] key, input logic [63:0] data, input logic dec,
                       input logic [63:0] exp_data, input logic exp_err);
    int n = 0;
    in_key = key; in_data = data; in_decrypt = dec; in_valid = 1'b1;
    push_exp(exp_data, exp_err);
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL accept_timeout in_ready=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_key = ~key; in_data = ~data; in_decrypt = ~dec;
  endtask

  task automatic collect(input string name, input bit check_lat);
    int n = 0;
    exp_t e;
    out_ready = 1'b0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("[TB] FAIL %s_timeout out_valid=%b required=1", name, out_valid);
      return;
    end
    if (check_lat) begin
      total++;
      if (n !== 16) begin bad++; $display("[TB] FAIL %s_latency got=%0d required=16", name, n); end
    end
    total++;
    if (sb.size() == 0) begin
      bad++; $display("[TB] FAIL %s_scoreboard_empty got=0 required=1", name);
      return;
    end
    e = sb.pop_front();
    if (out_data !== e.data) begin
      bad++; $display("[TB] FAIL %s_data got=%h required=%h", name, out_data, e.data);
    end
    total++;
    if (out_err !== e.err) begin
      bad++; $display("[TB] FAIL %s_err got=%b required=%b", name, out_err, e.err);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL %s_release out_valid=%b in_ready=%b required=0,1", name, out_valid, in_ready);
    end
  endtask

  task automatic check_reset_values(input string name);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'h0 || out_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s got rdy=%b vld=%b data=%h err=%b busy=%b required 1,0,0,0,0",
               name, in_ready, out_valid, out_data, out_err, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; in_key = '0; in_data = '0; out_ready = 1'b0;
    #12;
    check_reset_values("reset_asserted");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset_released");
  endtask

  task automatic test_encrypt();
    issue(K1, PT, 1'b0, CT, 1'b0);
    collect("enc_k1", 1'b1);
    issue(K2, P2, 1'b0, 64'h0, 1'b0);
    collect("enc_k2", 1'b1);
  endtask

  task automatic test_decrypt();
    issue(K1, CT, 1'b1, PT, 1'b0);
    collect("dec_k1", 1'b1);
    issue(K2, 64'h0, 1'b1, P2, 1'b0);
    collect("dec_k2", 1'b1);
  endtask

  task automatic test_backpressure();
    int n = 0;
    issue(K1, PT, 1'b0, CT, 1'b0);
    out_ready = 1'b0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 3);
      in_key = K2; in_data = P2; in_decrypt = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== CT || in_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_hold cycle=%0d vld=%b data=%h rdy=%b required 1,%h,0",
                 c, out_valid, out_data, in_ready, CT);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    collect("bp", 1'b0);
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; end
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL bp_no_queue vld=%b busy=%b required 0,0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc = 0;
    int   hs_cyc = -1;
    int   acc_cyc = -1;
    int   results = 0;
    exp_t e;
    out_ready = 1'b1;
    issue(K1, PT, 1'b0, CT, 1'b0);
    in_key = K2; in_data = P2; in_decrypt = 1'b0; in_valid = 1'b1;
    push_exp(64'h0, 1'b0);
    while (results < 2 && cyc < 120) begin
      if (out_valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("[TB] FAIL b2b_scoreboard_empty got=0 required=1");
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data) begin
            bad++; $display("[TB] FAIL b2b_data%0d got=%h required=%h", results, out_data, e.data);
          end
        end
        if (results == 0) hs_cyc = cyc;
        results++;
      end
      if (in_ready && in_valid) acc_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
      if (acc_cyc >= 0) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    total++;
    if (results != 2) begin
      bad++; $display("[TB] FAIL b2b_timeout results=%0d required=2", results);
    end
    total++;
    if (acc_cyc !== hs_cyc + 1) begin
      bad++; $display("[TB] FAIL b2b_accept_cycle got=%0d required=%0d", acc_cyc, hs_cyc + 1);
    end
  endtask

  task automatic test_reset_mid();
    issue(K1, PT, 1'b0, CT, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy got=%b required=1", busy); end
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; end
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_stale vld=%b busy=%b required 0,0", out_valid, busy);
    end
    issue(K2, P2, 1'b0, 64'h0, 1'b0);
    collect("after_reset", 1'b1);
  endtask

  task automatic test_zero_key();
    issue(64'h0, 64'h0, 1'b0, ZC, ZERO_KEY_ERR);
    collect("zero_key", 1'b1);
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_zero_key();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
